// File: rtl/snr_cal_sequencer.sv
// Calibration/settle/run sequencer between the audio stream, snr_calculator and the display.
// Audio path is combinational pass-through; the SNR path is a one-entry register slice with a peak-hold value.
module snr_cal_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int SNR_WIDTH      = 8,
  parameter int CAL_SAMPLES    = 48000,
  parameter int SETTLE_SAMPLES = 4800,
  parameter int CNT_WIDTH      = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         recal_req,
  input  logic        [DATA_WIDTH-1:0] audio_input,
  input  logic                         audio_input_valid,
  output logic                         audio_input_ready,
  output logic        [DATA_WIDTH-1:0] calc_audio,
  output logic                         calc_audio_valid,
  input  logic                         calc_audio_ready,
  output logic                         quiet_period,
  input  logic signed [SNR_WIDTH-1:0]  snr_in,
  input  logic                         snr_in_valid,
  output logic                         snr_in_ready,
  output logic signed [SNR_WIDTH-1:0]  snr_out,
  output logic                         snr_out_valid,
  input  logic                         snr_out_ready,
  output logic signed [SNR_WIDTH-1:0]  snr_peak,
  output logic                         cal_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAL,
    S_SETTLE,
    S_RUN
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CAL_LAST    = CNT_WIDTH'(CAL_SAMPLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_SAMPLES - 1);
  localparam logic signed [SNR_WIDTH-1:0] PEAK_MIN = {1'b1, {(SNR_WIDTH-1){1'b0}}};

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [CNT_WIDTH-1:0]         r_cnt;
  logic [CNT_WIDTH-1:0]         w_cnt_nxt;
  logic signed [SNR_WIDTH-1:0]  r_snr_out;
  logic signed [SNR_WIDTH-1:0]  r_peak;
  logic                         r_snr_vld;

  logic w_accept;
  logic w_run;
  logic w_recal;
  logic w_in_hs;
  logic w_out_hs;

  assign w_run    = (r_state == S_RUN);
  assign w_recal  = recal_req && (r_state != S_IDLE);

  assign calc_audio        = audio_input;
  assign calc_audio_valid  = audio_input_valid && (r_state != S_IDLE);
  assign audio_input_ready = (r_state == S_IDLE) ? 1'b1 : calc_audio_ready;
  assign w_accept          = calc_audio_valid && calc_audio_ready;

  // Both flags come straight off the state register so the calculator never sees input glitches.
  assign quiet_period = (r_state == S_CAL);
  assign cal_done     = w_run;

  assign snr_in_ready  = w_run ? (!r_snr_vld || snr_out_ready) : 1'b1;
  assign w_in_hs       = w_run && snr_in_valid && snr_in_ready;
  assign w_out_hs      = r_snr_vld && snr_out_ready;
  assign snr_out       = r_snr_out;
  assign snr_out_valid = r_snr_vld;
  assign snr_peak      = r_peak;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CAL;
          w_cnt_nxt   = '0;
        end
      end
      S_CAL: begin
        if (w_recal) begin
          w_cnt_nxt = '0;
        end else if (w_accept) begin
          if (r_cnt == CAL_LAST) begin
            w_state_nxt = S_SETTLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (w_recal) begin
          w_state_nxt = S_CAL;
          w_cnt_nxt   = '0;
        end else if (w_accept) begin
          if (r_cnt == SETTLE_LAST) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_recal) begin
          w_state_nxt = S_CAL;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Recal wins over any slice activity in the same cycle; the offered word is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snr_out <= '0;
      r_snr_vld <= 1'b0;
      r_peak    <= PEAK_MIN;
    end else if (w_recal) begin
      r_snr_vld <= 1'b0;
      r_peak    <= PEAK_MIN;
    end else if (w_in_hs) begin
      r_snr_out <= snr_in;
      r_snr_vld <= 1'b1;
      if (snr_in > r_peak) begin
        r_peak <= snr_in;
      end
    end else if (w_out_hs) begin
      r_snr_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snr_cal_sequencer.sv
// Directed bench for snr_cal_sequencer with CAL_SAMPLES=4, SETTLE_SAMPLES=2, SNR_WIDTH=8.
module tb_snr_cal_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        recal_req;
  logic [15:0] audio_input;
  logic        audio_input_valid;
  logic        audio_input_ready;
  logic [15:0] calc_audio;
  logic        calc_audio_valid;
  logic        calc_audio_ready;
  logic        quiet_period;
  logic [7:0]  snr_in;
  logic        snr_in_valid;
  logic        snr_in_ready;
  logic [7:0]  snr_out;
  logic        snr_out_valid;
  logic        snr_out_ready;
  logic [7:0]  snr_peak;
  logic        cal_done;

  int n_chk  = 0;
  int n_pass = 0;

  snr_cal_sequencer #(
    .DATA_WIDTH(16), .SNR_WIDTH(8), .CAL_SAMPLES(4), .SETTLE_SAMPLES(2), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .recal_req(recal_req),
    .audio_input(audio_input), .audio_input_valid(audio_input_valid),
    .audio_input_ready(audio_input_ready), .calc_audio(calc_audio),
    .calc_audio_valid(calc_audio_valid), .calc_audio_ready(calc_audio_ready),
    .quiet_period(quiet_period), .snr_in(snr_in), .snr_in_valid(snr_in_valid),
    .snr_in_ready(snr_in_ready), .snr_out(snr_out), .snr_out_valid(snr_out_valid),
    .snr_out_ready(snr_out_ready), .snr_peak(snr_peak), .cal_done(cal_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    #3;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      audio_input_valid = 1'b1;
      calc_audio_ready  = 1'b1;
      nxt();
    end
    audio_input_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_quiet"}, quiet_period, 0);
    check({tag, "_caldone"}, cal_done, 0);
    check({tag, "_snr_out"}, snr_out, 0);
    check({tag, "_snr_vld"}, snr_out_valid, 0);
    check({tag, "_peak"}, snr_peak, 8'h80);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; recal_req = 1'b0;
    audio_input = '0; audio_input_valid = 1'b0; calc_audio_ready = 1'b0;
    snr_in = '0; snr_in_valid = 1'b0; snr_out_ready = 1'b0;
    #1;
    check_reset_outputs("rst");
    nxt();
    reset = 1'b0;

    // Idle: samples are swallowed, nothing reaches the calculator
    for (int i = 0; i < 5; i++) begin
      audio_input_valid = 1'b1; calc_audio_ready = 1'b1; audio_input = 16'(i);
      mid();
      check("idle_calc_vld", calc_audio_valid, 0);
      check("idle_in_rdy", audio_input_ready, 1);
      check("idle_quiet", quiet_period, 0);
      nxt();
    end
    check("idle_stay", calc_audio_valid, 0);

    // Sequence: start then 8 back-to-back samples
    start = 1'b1;
    nxt();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      audio_input = 16'(i * 100 + 1); audio_input_valid = 1'b1; calc_audio_ready = 1'b1;
      snr_in_valid = (i == 0 || i == 6);
      snr_in = (i == 0) ? 8'd7 : 8'd12;
      snr_out_ready = 1'b1;
      mid();
      check("seq_pass_dat", calc_audio, 16'(i * 100 + 1));
      check("seq_pass_vld", calc_audio_valid, 1);
      check("seq_quiet", quiet_period, (i < 4) ? 1 : 0);
      check("seq_caldone", cal_done, (i >= 6) ? 1 : 0);
      check("seq_snr_vld", snr_out_valid, (i == 7) ? 1 : 0);
      if (i == 0) check("seq_drop_rdy", snr_in_ready, 1);
      if (i == 7) check("seq_snr_out", snr_out, 12);
      nxt();
    end
    audio_input_valid = 1'b0; snr_in_valid = 1'b0;
    mid();
    check("seq_drained", snr_out_valid, 0);
    nxt();

    // Slice: stall the display, then release it
    snr_out_ready = 1'b0; snr_in_valid = 1'b1; snr_in = 8'd5;
    mid();
    check("slc_rdy0", snr_in_ready, 1);
    nxt();
    snr_in = 8'hFD;
    mid();
    check("slc_hold_a", snr_out, 5);
    check("slc_vld_a", snr_out_valid, 1);
    check("slc_inrdy_a", snr_in_ready, 0);
    nxt();
    mid();
    check("slc_hold_b", snr_out, 5);
    check("slc_inrdy_b", snr_in_ready, 0);
    snr_out_ready = 1'b1;
    #1;
    check("slc_release_rdy", snr_in_ready, 1);
    check("slc_deliver5", snr_out, 5);
    nxt();
    snr_in_valid = 1'b0;
    mid();
    check("slc_deliver_m3", snr_out, 8'hFD);
    check("slc_vld_m3", snr_out_valid, 1);
    nxt();
    mid();
    check("slc_no_dup", snr_out_valid, 0);
    check("slc_peak", snr_peak, 12);
    nxt();

    // Recal while a word is held
    snr_out_ready = 1'b0; snr_in_valid = 1'b1; snr_in = 8'd20;
    nxt();
    snr_in_valid = 1'b0;
    mid();
    check("pre_recal_vld", snr_out_valid, 1);
    check("pre_recal_peak", snr_peak, 20);
    nxt();
    recal_req = 1'b1;
    nxt();
    recal_req = 1'b0;
    mid();
    check("recal1_peak", snr_peak, 8'h80);
    check("recal1_quiet", quiet_period, 1);
    check("recal1_caldone", cal_done, 0);
    check("recal1_vld", snr_out_valid, 0);
    nxt();

    // Backpressure in CALIBRATE: 2 accepts, 3 stalls, 2 accepts
    for (int i = 0; i < 7; i++) begin
      audio_input_valid = 1'b1;
      calc_audio_ready = !(i >= 2 && i < 5);
      mid();
      check("bp_quiet", quiet_period, 1);
      if (i >= 2 && i < 5) check("bp_stall_rdy", audio_input_ready, 0);
      nxt();
    end
    audio_input_valid = 1'b0;
    mid();
    check("bp_settle_quiet", quiet_period, 0);
    check("bp_settle_caldone", cal_done, 0);
    nxt();
    feed(2);
    mid();
    check("bp_run", cal_done, 1);
    nxt();

    // Peak over 3, -2, 9, 4
    for (int i = 0; i < 4; i++) begin
      snr_out_ready = 1'b1; snr_in_valid = 1'b1;
      case (i)
        0: snr_in = 8'd3;
        1: snr_in = 8'hFE;
        2: snr_in = 8'd9;
        default: snr_in = 8'd4;
      endcase
      nxt();
      mid();
      case (i)
        0: check("pk_0", snr_peak, 3);
        1: check("pk_1", snr_peak, 3);
        2: check("pk_2", snr_peak, 9);
        default: check("pk_3", snr_peak, 9);
      endcase
      #1;
    end
    snr_in_valid = 1'b0;
    check("pk_last_out", snr_out, 4);
    recal_req = 1'b1;
    nxt();
    recal_req = 1'b0;
    mid();
    check("recal2_peak", snr_peak, 8'h80);
    check("recal2_quiet", quiet_period, 1);
    check("recal2_caldone", cal_done, 0);
    check("recal2_vld", snr_out_valid, 0);
    nxt();

    // Async reset mid-RUN with a word held
    feed(6);
    mid();
    check("ar_run", cal_done, 1);
    nxt();
    snr_out_ready = 1'b0; snr_in_valid = 1'b1; snr_in = 8'd50;
    nxt();
    snr_in_valid = 1'b0;
    #1;
    check("ar_pre_vld", snr_out_valid, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("arst");
    audio_input_valid = 1'b1;
    #1;
    check("arst_idle_calc_vld", calc_audio_valid, 0);
    check("arst_idle_rdy", audio_input_ready, 1);
    audio_input_valid = 1'b0;
    nxt();
    reset = 1'b0;
    nxt();
    mid();
    check("post_arst_quiet", quiet_period, 0);
    nxt();

    // recal alone in IDLE is ignored; start+recal together starts
    recal_req = 1'b1;
    nxt();
    recal_req = 1'b0;
    mid();
    check("idle_recal_ignored", quiet_period, 0);
    nxt();
    start = 1'b1; recal_req = 1'b1;
    nxt();
    start = 1'b0; recal_req = 1'b0;
    mid();
    check("start_recal_idle", quiet_period, 1);
    nxt();

    // start in CALIBRATE must not clear the count
    feed(2);
    start = 1'b1;
    nxt();
    start = 1'b0;
    feed(2);
    mid();
    check("start_ignored_cal", quiet_period, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
